// File: rtl/ext_euclidean_pkg.sv
// Shared types for the extended-Euclidean inverse engine: FSM states and
// the signed Bezout-coefficient width helper.
package ext_euclidean_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    DIV    = 3'd2,
    UPDATE = 3'd3,
    CHECK  = 3'd4,
    NORM   = 3'd5,
    FAIL   = 3'd6,
    DONE   = 3'd7
  } state_t;

  // Two guard bits: |s|,|t| stay below the modulus and |q*s1| below twice it.
  localparam int COEF_GUARD = 2;

  function automatic int coef_w(input int width);
    return width + COEF_GUARD;
  endfunction

endpackage

// File: rtl/ext_euclidean_div.sv
// Bit-serial restoring divider (one quotient bit per cycle, MSB first) with
// shift-add accumulators forming q*s1 and q*t1 without a wide multiplier.
module ext_euclidean_div
  import ext_euclidean_pkg::*;
#(
  parameter int WIDTH = 512,
  localparam int CW   = coef_w(WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_dividend,
  input  logic [WIDTH-1:0]     i_divisor,
  input  logic signed [CW-1:0] i_s1,
  input  logic signed [CW-1:0] i_t1,
  output logic                 o_busy,
  output logic                 o_last,
  output logic                 o_qbit,
  output logic [WIDTH-1:0]     o_rem,
  output logic signed [CW-1:0] o_qs,
  output logic signed [CW-1:0] o_qt
);

  localparam int CNT_W = $clog2(WIDTH);

  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic signed [CW-1:0] r_qs;
  logic signed [CW-1:0] r_qt;

  logic                 w_active;
  logic [CNT_W-1:0]     w_idx;
  logic [WIDTH-1:0]     w_rem_in;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic signed [CW-1:0] w_qs_in;
  logic signed [CW-1:0] w_qt_in;
  logic signed [CW-1:0] w_qs_nxt;
  logic signed [CW-1:0] w_qt_nxt;

  // The start cycle already consumes the top dividend bit from a cleared remainder.
  always_comb begin
    w_active  = i_start | r_busy;
    w_idx     = i_start ? CNT_W'(WIDTH - 1) : r_cnt;
    w_rem_in  = i_start ? '0 : r_rem;
    w_qs_in   = i_start ? '0 : r_qs;
    w_qt_in   = i_start ? '0 : r_qt;
    w_trial   = {w_rem_in, i_dividend[w_idx]};
    w_diff    = w_trial - {1'b0, i_divisor};
    w_qbit    = ~w_diff[WIDTH];
    w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_qs_nxt  = (w_qs_in <<< 1) + (w_qbit ? i_s1 : '0);
    w_qt_nxt  = (w_qt_in <<< 1) + (w_qbit ? i_t1 : '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_qs   <= '0;
      r_qt   <= '0;
    end else if (w_active) begin
      r_busy <= (w_idx != '0);
      r_cnt  <= w_idx - 1'b1;
      r_rem  <= w_rem_nxt;
      r_qs   <= w_qs_nxt;
      r_qt   <= w_qt_nxt;
    end
  end

  assign o_busy = r_busy;
  assign o_last = r_busy & (r_cnt == '0);
  assign o_qbit = w_qbit & w_active;
  assign o_rem  = r_rem;
  assign o_qs   = r_qs;
  assign o_qt   = r_qt;

endmodule

// File: rtl/ext_euclidean.sv
// Free-running extended-Euclidean engine: N^-1 mod M and M^-1 mod N.
// Optional error output is compiled in with `define EXT_EUCLID_ERROR_EN.
module ext_euclidean
  import ext_euclidean_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] Multiplicative_Num,
  input  logic [WIDTH-1:0] Modular,
  output logic [WIDTH-1:0] Multiplicative_Inv_Mod,
  output logic [WIDTH-1:0] Multiplicative_Inv_Num,
  output logic             done
`ifdef EXT_EUCLID_ERROR_EN
  ,
  output logic             error
`endif
);

  localparam int CW = coef_w(WIDTH);

  state_t               r_state;
  logic [WIDTH-1:0]     r_n;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_r0;
  logic [WIDTH-1:0]     r_r1;
  logic signed [CW-1:0] r_s0;
  logic signed [CW-1:0] r_s1;
  logic signed [CW-1:0] r_t0;
  logic signed [CW-1:0] r_t1;
  logic [WIDTH-1:0]     r_inv_mod;
  logic [WIDTH-1:0]     r_inv_num;
  logic                 r_done;
`ifdef EXT_EUCLID_ERROR_EN
  logic                 r_error;
`endif

  logic                 w_div_start;
  logic                 w_div_busy;
  logic                 w_div_last;
  logic                 w_div_qbit;
  logic [WIDTH-1:0]     w_rem;
  logic signed [CW-1:0] w_qs;
  logic signed [CW-1:0] w_qt;

  // Bezout coefficients are bounded by the modulus, so a single add lands in [0,m).
  function automatic logic [WIDTH-1:0] wrap_pos(input logic [WIDTH-1:0] v_lo,
                                                input logic             v_neg,
                                                input logic [WIDTH-1:0] m);
    return v_neg ? v_lo + m : v_lo;
  endfunction

  assign w_div_start = (r_state == DIV) && !w_div_busy;

  ext_euclidean_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .i_clk      (aclk),
    .i_rst      (aresetn),
    .i_start    (w_div_start),
    .i_dividend (r_r0),
    .i_divisor  (r_r1),
    .i_s1       (r_s1),
    .i_t1       (r_t1),
    .o_busy     (w_div_busy),
    .o_last     (w_div_last),
    .o_qbit     (w_div_qbit),
    .o_rem      (w_rem),
    .o_qs       (w_qs),
    .o_qt       (w_qt)
  );

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_m       <= '0;
      r_r0      <= '0;
      r_r1      <= '0;
      r_s0      <= '0;
      r_s1      <= '0;
      r_t0      <= '0;
      r_t1      <= '0;
      r_inv_mod <= '0;
      r_inv_num <= '0;
      r_done    <= 1'b0;
`ifdef EXT_EUCLID_ERROR_EN
      r_error   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_n     <= Multiplicative_Num;
          r_m     <= Modular;
`ifdef EXT_EUCLID_ERROR_EN
          r_error <= 1'b0;
`endif
          r_state <= INIT;
        end
        INIT: begin
          r_r0    <= r_m;
          r_r1    <= r_n;
          r_s0    <= CW'(1);
          r_s1    <= '0;
          r_t0    <= '0;
          r_t1    <= CW'(1);
          r_state <= ((r_n == '0) || (r_m == '0)) ? FAIL : DIV;
        end
        DIV: begin
          if (w_div_last) r_state <= UPDATE;
        end
        // Remainder sequence and both Bezout columns advance together.
        UPDATE: begin
          r_r0    <= r_r1;
          r_r1    <= w_rem;
          r_s0    <= r_s1;
          r_s1    <= r_s0 - w_qs;
          r_t0    <= r_t1;
          r_t1    <= r_t0 - w_qt;
          r_state <= (w_rem == '0) ? CHECK : DIV;
        end
        CHECK: begin
          r_state <= (r_r0 != WIDTH'(1)) ? FAIL : NORM;
        end
        NORM: begin
          r_inv_num <= wrap_pos(r_t0[WIDTH-1:0], r_t0[CW-1], r_m);
          r_inv_mod <= wrap_pos(r_s0[WIDTH-1:0], r_s0[CW-1], r_n);
          r_done    <= 1'b1;
          r_state   <= DONE;
        end
        FAIL: begin
          r_inv_num <= '0;
          r_inv_mod <= '0;
          r_done    <= 1'b1;
`ifdef EXT_EUCLID_ERROR_EN
          r_error   <= 1'b1;
`endif
          r_state   <= DONE;
        end
        DONE: begin
          if ((Multiplicative_Num != r_n) || (Modular != r_m)) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Multiplicative_Inv_Mod = r_inv_mod;
  assign Multiplicative_Inv_Num = r_inv_num;
  assign done                   = r_done;
`ifdef EXT_EUCLID_ERROR_EN
  assign error                  = r_error;
`endif

endmodule

// File: tb/tb_ext_euclidean.sv
// Scoreboard bench for ext_euclidean at WIDTH=16: directed plus random operand
// pairs, expectations from an integer modular-inverse model.
module tb_ext_euclidean;

  localparam int W      = 16;
  localparam int BUDGET = 5000;

  logic         aclk = 1'b0;
  logic         rst;
  logic [W-1:0] n_in;
  logic [W-1:0] m_in;
  logic [W-1:0] inv_mod;
  logic [W-1:0] inv_num;
  logic         done;
`ifdef EXT_EUCLID_ERROR_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] mod;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  ext_euclidean #(
    .WIDTH(W)
  ) dut (
    .aclk                   (aclk),
    .aresetn                (rst),
    .Multiplicative_Num     (n_in),
    .Modular                (m_in),
    .Multiplicative_Inv_Mod (inv_mod),
    .Multiplicative_Inv_Num (inv_num),
    .done                   (done)
`ifdef EXT_EUCLID_ERROR_EN
    ,
    .error                  (err)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint gcd(input longint a, input longint b);
    longint x = a;
    longint y = b;
    longint t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Inverse of a modulo m via the classic (t, newt) recurrence, reduced into [0,m).
  function automatic longint inv(input longint a, input longint m);
    longint t = 0, nt = 1, r = m, nr = a % m, q, tmp;
    if (m == 1) return 0;
    while (nr != 0) begin
      q   = r / nr;
      tmp = t - q * nt;  t = nt;  nt = tmp;
      tmp = r - q * nr;  r = nr;  nr = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

  function automatic exp_t model(input longint n, input longint m);
    exp_t e;
    e.num = '0;
    e.mod = '0;
    e.err = 1'b1;
    if (n != 0 && m != 0 && gcd(n, m) == 1) begin
      e.num = W'(inv(n, m));
      e.mod = W'(inv(m, n));
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < BUDGET) begin
      @(negedge aclk);
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=done0 required=done1 after %0d cycles", name, BUDGET);
      exp_q.delete();
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic run(input string name, input logic [W-1:0] n, input logic [W-1:0] m);
    int k = 0;
    n_in = n;
    m_in = m;
    exp_q.push_back(model(longint'(n), longint'(m)));
    while (done && k < 20) begin
      @(negedge aclk);
      k++;
    end
    chk({name, "_done_drop"}, longint'(done), 0);
    wait_done(name);
  endtask

  // Monitor: every rising edge of done is one completed result.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (done && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=n%0d/m%0d required=no_result", inv_num, inv_mod);
        end else begin
          e = exp_q.pop_front();
          chk("inv_num", longint'(inv_num), longint'(e.num));
          chk("inv_mod", longint'(inv_mod), longint'(e.mod));
`ifdef EXT_EUCLID_ERROR_EN
          chk("error", longint'(err), longint'(e.err));
`endif
        end
      end
      prev = done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] rn, rm;
    rst  = 1'b1;
    n_in = W'(3);
    m_in = W'(640);
    repeat (3) @(negedge aclk);
    chk("rst_done", longint'(done), 0);
    chk("rst_inv_num", longint'(inv_num), 0);
    chk("rst_inv_mod", longint'(inv_mod), 0);
`ifdef EXT_EUCLID_ERROR_EN
    chk("rst_error", longint'(err), 0);
`endif
    exp_q.push_back(model(3, 640));
    rst = 1'b0;
    @(negedge aclk);
    chk("post_rel_done", longint'(done), 0);
    wait_done("first");

    run("n17_m3120", W'(17), W'(3120));
    run("n7_m40", W'(7), W'(40));
    run("n40_m7", W'(40), W'(7));
    run("n4_gcd4", W'(4), W'(640));
    run("n0", W'(0), W'(640));
    run("n1_m640", W'(1), W'(640));
    run("full_width", W'(65535), W'(32768));
    run("n3_m1", W'(3), W'(1));
    run("n0_m0", W'(0), W'(0));
    run("n7_m40_again", W'(7), W'(40));

    // Abort mid-division, then confirm a clean recompute.
    n_in = W'(3);
    m_in = W'(640);
    repeat (6) @(negedge aclk);
    chk("mid_pre_done", longint'(done), 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_inv_num", longint'(inv_num), 0);
    chk("abort_inv_mod", longint'(inv_mod), 0);
    chk("abort_done", longint'(done), 0);
    repeat (2) @(negedge aclk);
    exp_q.push_back(model(3, 640));
    rst = 1'b0;
    wait_done("after_abort");

    for (int i = 0; i < 14; i++) begin
      do begin
        if ($urandom_range(0, 2) == 0) begin
          rn = W'($urandom_range(1, 60));
          rm = W'($urandom_range(1, 60));
        end else begin
          rn = W'($urandom_range(1, 65535));
          rm = W'($urandom_range(1, 65535));
        end
      end while ((rn == n_in && rm == m_in) || (rn == W'(1) && rm == W'(1)));
      run("random", rn, rm);
    end

    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
